// File: rtl/alm_mac_pkg.sv
// Shared definitions for the ALM 2-bit MAC dot-product datapath.
// The sequencer state encoding and the MAC geometry live here.
package alm_mac_pkg;

  localparam int MAC_OP_W        = 2;
  localparam int MAC_RES_W       = 8;
  localparam int MAC_LAT_DEFAULT = 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    DRAIN,
    DONE
  } seq_state_e;

endpackage

// File: rtl/alm_mac_dot_sequencer_if.sv
// Operand-in / result-out handshake bundle of the dot-product sequencer.
// The master is the operand buffer and result consumer; the slave is the sequencer.
interface alm_mac_dot_sequencer_if
  import alm_mac_pkg::*;
#(
  parameter int VEC_LEN = 4,
  parameter int OP_W    = MAC_OP_W,
  parameter int RES_W   = MAC_RES_W
);

  logic                    in_valid;
  logic                    in_ready;
  logic [OP_W*VEC_LEN-1:0] in_a;
  logic [OP_W*VEC_LEN-1:0] in_b;
  logic                    out_valid;
  logic                    out_ready;
  logic [RES_W-1:0]        out_result;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result
  );

endinterface

// File: rtl/alm_mac_dot_sequencer.sv
// Feeds one packed vector pair into the 2-bit ALM MAC element by element and
// returns the accumulated dot product once the MAC pipeline has settled.
//
// state | meaning
// IDLE  | ready for a new vector pair
// CLEAR | one-cycle synchronous clear of the MAC accumulator
// ISSUE | one element pair per cycle with acc_en high, element 0 first
// DRAIN | wait MAC_LAT cycles, capture mac_result at the end of the last one
// DONE  | hold the result until the consumer takes it
module alm_mac_dot_sequencer
  import alm_mac_pkg::*;
#(
  parameter int VEC_LEN = 4,
  parameter int OP_W    = MAC_OP_W,
  parameter int RES_W   = MAC_RES_W,
  parameter int MAC_LAT = MAC_LAT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  alm_mac_dot_sequencer_if.slave s_if,
  output logic                   busy,
  output logic                   mac_reset,
  output logic                   mac_acc_en,
  output logic [OP_W-1:0]        mac_a,
  output logic [OP_W-1:0]        mac_b,
  input  logic [RES_W-1:0]       mac_result
);

  localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MAC_LAT - 1);

  seq_state_e              r_state;
  seq_state_e              w_state_nxt;
  logic [IDX_W-1:0]        r_idx;
  logic [LAT_W-1:0]        r_lat_cnt;
  logic [OP_W*VEC_LEN-1:0] r_a;
  logic [OP_W*VEC_LEN-1:0] r_b;
  logic [RES_W-1:0]        r_result;
  logic                    w_issue;
  logic                    w_last;

  assign w_issue = (r_state == ISSUE);
  assign w_last  = (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (s_if.in_valid) w_state_nxt = CLEAR;
      CLEAR:   w_state_nxt = ISSUE;
      ISSUE:   if (w_last) w_state_nxt = DRAIN;
      DRAIN:   if (r_lat_cnt == '0) w_state_nxt = DONE;
      DONE:    if (s_if.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operands shift down one element per ISSUE cycle so the MAC always sees the LSB slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx     <= '0;
      r_lat_cnt <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_if.in_valid) begin
            r_a <= s_if.in_a;
            r_b <= s_if.in_b;
          end
        end
        CLEAR: begin
          r_idx <= '0;
        end
        ISSUE: begin
          r_a <= r_a >> OP_W;
          r_b <= r_b >> OP_W;
          if (w_last) begin
            r_idx     <= '0;
            r_lat_cnt <= LAT_INIT;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DRAIN: begin
          if (r_lat_cnt == '0) begin
            r_result <= mac_result;
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign s_if.in_ready   = (r_state == IDLE);
  assign s_if.out_valid  = (r_state == DONE);
  assign s_if.out_result = r_result;
  assign busy            = (r_state != IDLE);
  assign mac_reset       = (r_state == CLEAR);
  assign mac_acc_en      = w_issue;
  assign mac_a           = w_issue ? r_a[OP_W-1:0] : '0;
  assign mac_b           = w_issue ? r_b[OP_W-1:0] : '0;

endmodule

// File: tb/tb_alm_mac_dot_sequencer.sv
// Bench for alm_mac_dot_sequencer: two instances (MAC latency 1 and 3), each
// driving a small behavioural MAC, with results checked against a scoreboard.
module tb_alm_mac_dot_sequencer;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
  } vec_t;

  logic clk;
  logic reset_n;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  alm_mac_dot_sequencer_if #(.VEC_LEN(4), .OP_W(2), .RES_W(8)) if0 ();
  alm_mac_dot_sequencer_if #(.VEC_LEN(4), .OP_W(2), .RES_W(8)) if1 ();

  logic       busy0, mac_reset0, mac_acc_en0;
  logic [1:0] mac_a0, mac_b0;
  logic [7:0] mac_result0;
  logic       busy1, mac_reset1, mac_acc_en1;
  logic [1:0] mac_a1, mac_b1;
  logic [7:0] mac_result1;

  alm_mac_dot_sequencer #(.VEC_LEN(4), .OP_W(2), .RES_W(8), .MAC_LAT(1)) u_dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_if       (if0),
    .busy       (busy0),
    .mac_reset  (mac_reset0),
    .mac_acc_en (mac_acc_en0),
    .mac_a      (mac_a0),
    .mac_b      (mac_b0),
    .mac_result (mac_result0)
  );

  alm_mac_dot_sequencer #(.VEC_LEN(4), .OP_W(2), .RES_W(8), .MAC_LAT(3)) u_dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_if       (if1),
    .busy       (busy1),
    .mac_reset  (mac_reset1),
    .mac_acc_en (mac_acc_en1),
    .mac_a      (mac_a1),
    .mac_b      (mac_b1),
    .mac_result (mac_result1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [7:0] sx(input logic [1:0] v);
    return {{6{v[1]}}, v};
  endfunction

  function automatic logic [7:0] pk(input int e0, input int e1, input int e2, input int e3);
    logic [1:0] x0, x1, x2, x3;
    x0 = 2'(e0); x1 = 2'(e1); x2 = 2'(e2); x3 = 2'(e3);
    return {x3, x2, x1, x0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural MACs: latency 1 is the accumulator itself, latency 3 adds two delay stages.
  logic signed [7:0] acc0, acc1, dly1a, dly1b;
  always @(posedge clk) begin
    if (mac_reset0) acc0 <= '0;
    else if (mac_acc_en0) acc0 <= acc0 + sx(mac_a0) * sx(mac_b0);
    if (mac_reset1) acc1 <= '0;
    else if (mac_acc_en1) acc1 <= acc1 + sx(mac_a1) * sx(mac_b1);
    dly1a <= acc1;
    dly1b <= dly1a;
  end
  assign mac_result0 = acc0;
  assign mac_result1 = dly1b;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int   acc_e0 = 0, out_e0 = 0, en0 = 0, clr0 = 0;
  int   acc_e1 = 0, en1 = 0;
  logic ov0_q = 1'b0, ov1_q = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    ov0_q <= if0.out_valid;
    ov1_q <= if1.out_valid;
    if (if0.in_valid && if0.in_ready) begin
      acc_e0 <= cyc; en0 <= 0; clr0 <= 0;
    end else begin
      if (mac_acc_en0) en0 <= en0 + 1;
      if (mac_reset0) clr0 <= clr0 + 1;
    end
    if (if1.in_valid && if1.in_ready) begin
      acc_e1 <= cyc; en1 <= 0;
    end else if (mac_acc_en1) begin
      en1 <= en1 + 1;
    end
    if (if0.out_valid && !ov0_q) begin
      chk("latency0", 32'(cyc - acc_e0), 32'(7));
      chk("acc_en_cycles0", 32'(en0), 32'(4));
      chk("clear_cycles0", 32'(clr0), 32'(1));
    end
    if (if1.out_valid && !ov1_q) begin
      chk("latency1", 32'(cyc - acc_e1), 32'(9));
      chk("acc_en_cycles1", 32'(en1), 32'(4));
    end
    if (if0.out_valid && if0.out_ready) begin
      out_e0 <= cyc;
      if (q0.size() == 0) chk("spurious_out0", 32'(if0.out_valid), 32'(0));
      else chk("result0", 32'(if0.out_result), 32'(q0.pop_front()));
    end
    if (if1.out_valid && if1.out_ready) begin
      if (q1.size() == 0) chk("spurious_out1", 32'(if1.out_valid), 32'(0));
      else chk("result1", 32'(if1.out_result), 32'(q1.pop_front()));
    end
  end

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send0(input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
    int n;
    n = 0;
    q0.push_back(e);
    if0.in_valid = 1'b1; if0.in_a = a; if0.in_b = b;
    while (!if0.in_ready && n < 40) begin @(negedge clk); n++; end
    chk("accept0_timeout", 32'(if0.in_ready), 32'(1));
    @(negedge clk);
    if0.in_valid = 1'b0;
  endtask

  task automatic wait_q0();
    int n;
    n = 0;
    while (q0.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain0_timeout", 32'(q0.size()), 32'(0));
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_in_ready"},   32'(if0.in_ready),   32'(1));
    chk({tag, "_out_valid"},  32'(if0.out_valid),  32'(0));
    chk({tag, "_out_result"}, 32'(if0.out_result), 32'(0));
    chk({tag, "_busy"},       32'(busy0),          32'(0));
    chk({tag, "_mac_reset"},  32'(mac_reset0),     32'(0));
    chk({tag, "_mac_acc_en"}, 32'(mac_acc_en0),    32'(0));
    chk({tag, "_mac_ab"},     32'({mac_a0, mac_b0}), 32'(0));
  endtask

  vec_t tbl[7];

  initial begin
    int n;
    tbl[0] = '{pk(-2, -1, 0, 1),   pk(1, 0, -2, -1),   8'hFD};
    tbl[1] = '{pk(-2, -2, -2, -2), pk(-2, -2, -2, -2), 8'h10};
    tbl[2] = '{pk(0, 0, 0, 0),     pk(0, 0, 0, 0),     8'h00};
    tbl[3] = '{pk(1, 1, 1, 1),     pk(1, -1, 1, 1),    8'h02};
    tbl[4] = '{pk(-2, -2, -2, -2), pk(1, 1, 1, 1),     8'hF8};
    tbl[5] = '{pk(1, -1, -2, 1),   pk(-2, -2, 1, 1),   8'hFF};
    tbl[6] = '{pk(-1, -1, -1, -1), pk(-1, 1, -2, -1),  8'h03};

    if0.in_valid = 1'b0; if0.in_a = '0; if0.in_b = '0; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0; if1.out_ready = 1'b1;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset0("por");
    reset_n = 1'b1;
    @(negedge clk);

    // Back-to-back vectors with the consumer always ready.
    for (int i = 0; i < 7; i++) begin
      send0(tbl[i].a, tbl[i].b, tbl[i].res);
      wait_q0();
    end

    // Back-pressure: result held 10 cycles while stray in_valid pulses are ignored.
    if0.out_ready = 1'b0;
    send0(tbl[0].a, tbl[0].b, tbl[0].res);
    n = 0;
    while (!if0.out_valid && n < 40) begin @(negedge clk); n++; end
    chk("bp_valid_timeout", 32'(if0.out_valid), 32'(1));
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid",  32'(if0.out_valid),  32'(1));
      chk("bp_out_result", 32'(if0.out_result), 32'(8'hFD));
      chk("bp_in_ready",   32'(if0.in_ready),   32'(0));
      if0.in_valid = i[0]; if0.in_a = 8'hFF; if0.in_b = 8'h55;
      @(negedge clk);
    end
    // out_ready and in_valid together in DONE: acceptance one cycle after the release.
    if0.out_ready = 1'b1;
    send0(tbl[1].a, tbl[1].b, tbl[1].res);
    chk("bubble_accept", 32'(acc_e0 - out_e0), 32'(1));
    wait_q0();

    // Asynchronous reset during the second ISSUE cycle.
    if0.in_valid = 1'b1; if0.in_a = pk(1, -2, 1, 1); if0.in_b = pk(1, 1, 1, 1);
    @(negedge clk);
    if0.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_acc_en", 32'(mac_acc_en0), 32'(1));
    chk("abort_mac_a",  32'(mac_a0),      32'(2'b10));
    chk("abort_busy",   32'(busy0),       32'(1));
    reset_n = 1'b0;
    #1;
    chk_reset0("abort");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send0(tbl[5].a, tbl[5].b, tbl[5].res);
    wait_q0();

    // MAC latency 3 instance.
    q1.push_back(8'h02);
    if1.in_valid = 1'b1; if1.in_a = pk(1, 1, 1, 1); if1.in_b = pk(1, -1, 1, 1);
    n = 0;
    while (!if1.in_ready && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    if1.in_valid = 1'b0;
    n = 0;
    while (q1.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain1_timeout", 32'(q1.size()), 32'(0));

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
